// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Single-cycle ops register their result on the
// accept edge. MUL is an iterative shift-add over WIDTH cycles. The result
// and its flags are held in DONE until the consumer takes them.
//
//   state | meaning
//   IDLE  | ready for a new operation (in_ready=1)
//   MUL   | shift-add multiply in progress, one partial product per cycle
//   DONE  | result valid, waiting for out_ready
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic [3:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);

  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b0001;
  localparam logic [3:0] F_AND  = 4'b0010;
  localparam logic [3:0] F_OR   = 4'b0011;
  localparam logic [3:0] F_XOR  = 4'b0100;
  localparam logic [3:0] F_NOR  = 4'b0101;
  localparam logic [3:0] F_SLL  = 4'b0110;
  localparam logic [3:0] F_SRL  = 4'b0111;
  localparam logic [3:0] F_SRA  = 4'b1000;
  localparam logic [3:0] F_SLT  = 4'b1001;
  localparam logic [3:0] F_SLTU = 4'b1010;
  localparam logic [3:0] F_MUL  = 4'b1011;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic             res_carry, res_ovf, res_illegal;
  logic             accept, mul_last;

  // State register; reset wins over any simultaneous request.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    accept    = in_valid && (state == IDLE);
    mul_last  = (cnt == CNT_LAST);
    case (state)
      IDLE: if (accept) state_nxt = (funct == F_MUL) ? MUL : DONE;
      MUL:  if (mul_last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle result and flags; the final MUL step folds in the last partial product.
  always_comb begin
    res         = '0;
    sum         = '0;
    res_carry   = 1'b0;
    res_ovf     = 1'b0;
    res_illegal = 1'b0;
    acc_nxt     = acc + (b_sh[0] ? a_sh : '0);
    case (funct)
      F_ADD: begin
        sum       = {1'b0, a} + {1'b0, b};
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      F_SUB: begin
        // a + ~b + 1: carry-out set means no borrow.
        sum       = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      F_AND:  res = a & b;
      F_OR:   res = a | b;
      F_XOR:  res = a ^ b;
      F_NOR:  res = ~(a | b);
      F_SLL:  res = a << shamt;
      F_SRL:  res = a >> shamt;
      F_SRA:  res = $unsigned($signed(a) >>> shamt);
      F_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      F_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      F_MUL:  res = '0;
      default: res_illegal = 1'b1;
    endcase
  end

  // Datapath registers: operand latch, multiplier iteration, result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (funct == F_MUL) begin
              a_sh <= a;
              b_sh <= b;
              acc  <= '0;
              cnt  <= '0;
            end else begin
              out     <= res;
              zero    <= (res == '0);
              carry   <= res_carry;
              ovf     <= res_ovf;
              illegal <= res_illegal;
            end
          end
        end
        MUL: begin
          acc  <= acc_nxt;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + SHW'(1);
          if (mul_last) begin
            out     <= acc_nxt;
            zero    <= (acc_nxt == '0);
            carry   <= 1'b0;
            ovf     <= 1'b0;
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq at WIDTH=32 and WIDTH=8
// against an arithmetic reference model.
module tb_alu_seq;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk, rst;

  logic        iv32, ir32, ov32, ordy32, z32, c32, v32, il32;
  logic [31:0] a32, b32, o32;
  logic [4:0]  sh32;
  logic [3:0]  f32;

  logic        iv8, ir8, ov8, ordy8, z8, c8, v8, il8;
  logic [7:0]  a8, b8, o8;
  logic [2:0]  sh8;
  logic [3:0]  f8;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .shamt(sh32), .funct(f32), .out_valid(ov32), .out_ready(ordy32), .out(o32),
    .zero(z32), .carry(c32), .ovf(v32), .illegal(il32)
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .shamt(sh8), .funct(f8), .out_valid(ov8), .out_ready(ordy8), .out(o8),
    .zero(z8), .carry(c8), .ovf(v8), .illegal(il8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result as {illegal, ovf, carry, zero, out}, from plain integer arithmetic.
  function automatic logic [35:0] ref32(input logic [3:0] f, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] s);
    logic [31:0] r, ones;
    logic c, v, il;
    longint ux, uy, sx, sy, t;
    r = 32'h0; c = 1'b0; v = 1'b0; il = 1'b0; ones = 32'hFFFF_FFFF;
    ux = longint'(x); uy = longint'(y);
    sx = longint'($signed(x)); sy = longint'($signed(y));
    case (f)
      4'd0: begin t = ux + uy; r = t[31:0]; c = t[32]; t = sx + sy; v = (t > SMAX) || (t < SMIN); end
      4'd1: begin t = ux - uy; r = t[31:0]; c = (ux >= uy); t = sx - sy; v = (t > SMAX) || (t < SMIN); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ~(x | y);
      4'd6: r = x << s;
      4'd7: r = x >> s;
      4'd8: r = (x >> s) | (x[31] ? ~(ones >> s) : 32'h0);
      4'd9: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd10: r = (ux < uy) ? 32'd1 : 32'd0;
      4'd11: begin t = ux * uy; r = t[31:0]; end
      default: il = 1'b1;
    endcase
    return {il, v, c, (r == 32'h0), r};
  endfunction

  // One operation on the 32-bit unit: accept, scramble inputs, measure latency, check, drain.
  task automatic op32(input string tag, input logic [3:0] f, input logic [31:0] x,
                      input logic [31:0] y, input logic [4:0] s);
    logic [35:0] e;
    int lat, exp_lat;
    e = ref32(f, x, y, s);
    exp_lat = (f == 4'd11) ? 33 : 1;
    chk({tag, " in_ready"}, 64'(ir32), 64'd1);
    iv32 = 1'b1; f32 = f; a32 = x; b32 = y; sh32 = s;
    @(negedge clk);
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom; f32 = 4'($urandom); sh32 = 5'($urandom);
    lat = 1;
    while (ov32 !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, 64'({il32, v32, c32, z32, o32}), 64'(e));
    ordy32 = 1'b1;
    @(negedge clk);
    ordy32 = 1'b0;
    chk({tag, " drain"}, 64'({ov32, ir32}), 64'(2'b01));
  endtask

  // MUL on the 8-bit unit with out_ready held high.
  task automatic mul8(input string tag, input logic [7:0] x, input logic [7:0] y);
    int lat, low;
    logic [15:0] p;
    p = 16'(x) * 16'(y);
    chk({tag, " in_ready"}, 64'(ir8), 64'd1);
    iv8 = 1'b1; f8 = 4'd11; a8 = x; b8 = y; ordy8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); f8 = 4'($urandom);
    lat = 1; low = 0;
    while (ov8 !== 1'b1 && lat < 40) begin
      if (ir8 === 1'b0) low++;
      @(negedge clk);
      lat++;
    end
    if (ir8 === 1'b0) low++;
    chk({tag, " latency"}, 64'(lat), 64'd9);
    chk({tag, " product"}, 64'(o8), 64'(p[7:0]));
    chk({tag, " zero"}, 64'(z8), 64'(p[7:0] == 8'h0));
    @(negedge clk);
    chk({tag, " in_ready low cycles"}, 64'(low), 64'd9);
    chk({tag, " drain"}, 64'({ov8, ir8}), 64'(2'b01));
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1;
    iv32 = 1'b0; ordy32 = 1'b0; a32 = '0; b32 = '0; sh32 = '0; f32 = '0;
    iv8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0; sh8 = '0; f8 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset 32", 64'({ir32, ov32, o32, z32, c32, v32, il32}), 64'({2'b10, 32'h0, 4'h0}));
    chk("reset 8", 64'({ir8, ov8, o8, z8, c8, v8, il8}), 64'({2'b10, 8'h0, 4'h0}));

    op32("add ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
    op32("sub eq", 4'd1, 32'd5, 32'd5, 5'd0);
    op32("sub borrow", 4'd1, 32'd3, 32'd5, 5'd0);
    op32("sra", 4'd8, 32'h8000_0010, 32'h0, 5'd4);
    op32("srl", 4'd7, 32'h8000_0010, 32'h0, 5'd4);
    op32("sll", 4'd6, 32'h8000_0010, 32'h0, 5'd4);
    op32("sra0", 4'd8, 32'h8000_0010, 32'h0, 5'd0);
    op32("slt", 4'd9, 32'hFFFF_FFFF, 32'h1, 5'd0);
    op32("sltu", 4'd10, 32'hFFFF_FFFF, 32'h1, 5'd0);
    op32("add carry", 4'd0, 32'hFFFF_FFFF, 32'h1, 5'd0);
    op32("mul32", 4'd11, 32'd13, 32'd11, 5'd0);
    op32("mul32 ff", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    op32("illegal", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);

    for (int i = 0; i < 40; i++) begin
      op32($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom));
    end

    mul8("mul8 13x11", 8'd13, 8'd11);
    mul8("mul8 ffxff", 8'hFF, 8'hFF);
    mul8("mul8 x0", 8'hA5, 8'h00);

    // Back-pressure: result held and new requests ignored while out_ready=0.
    iv32 = 1'b1; f32 = 4'd0; a32 = 32'd100; b32 = 32'd23;
    @(negedge clk);
    chk("bp valid", 64'({ov32, ir32}), 64'(2'b10));
    held = 32'd123;
    for (int i = 0; i < 5; i++) begin
      iv32 = 1'b1; f32 = 4'd4; a32 = $urandom; b32 = $urandom;
      @(negedge clk);
      chk($sformatf("bp hold%0d", i), 64'({ov32, ir32, o32}), 64'({2'b10, held}));
    end
    iv32 = 1'b0; ordy32 = 1'b1;
    @(negedge clk);
    ordy32 = 1'b0;
    chk("bp release", 64'({ov32, ir32}), 64'(2'b01));
    @(negedge clk);
    chk("bp no stray", 64'({ov32, ir32, o32}), 64'({2'b01, held}));

    // Reset during a multiply aborts it.
    iv8 = 1'b1; f8 = 4'd11; a8 = 8'd7; b8 = 8'd9; ordy8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst mid mul", 64'({ov8, ir8, o8}), 64'({2'b01, 8'h0}));
    repeat (10) @(negedge clk);
    chk("rst aborted", 64'({ov8, ir8}), 64'(2'b01));

    // Reset and request together: reset wins.
    iv32 = 1'b1; f32 = 4'd0; a32 = 32'd1; b32 = 32'd1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; iv32 = 1'b0;
    chk("rst vs valid", 64'({ov32, ir32, o32}), 64'({2'b01, 32'h0}));
    @(negedge clk);
    chk("rst vs valid later", 64'(ov32), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
